tx_sample_packer: RTL and testbench

Upstream stage of the LVDS transmit path. Accepts the host's byte stream of 16-bit signed I/Q samples, assembles each sample into one 32-bit word, and saturates I and Q to 13 bits. Writes the word into the TX sample FIFO, which the LVDS serializer drains through its empty/read handshake. Maintains byte alignment against a host start-of-frame marker and reports dropped words and alignment errors.

---
 rtl/tx_path_pkg.sv | 32 +++
 rtl/iq_saturate.sv | 26 ++
 rtl/tx_sample_packer.sv | 129 ++++++++++++
 tb/tb_tx_sample_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_path_pkg.sv
// Shared definitions for the LVDS transmit path: sample widths, word layout, FSM states.
package tx_path_pkg;

   localparam int IQ_W         = 13;
   localparam int SAMPLE_BYTES = 4;
   localparam int SAT_MAX      = 4095;
   localparam int SAT_MIN      = -4096;
   localparam int I_LSB        = 16;
   localparam int Q_LSB        = 0;

   typedef enum logic {
      ALIGN    = 1'b0,
      ASSEMBLE = 1'b1
   } state_e;

   // Raw 16-bit sample as assembled from the host byte stream.
   typedef struct packed {
      logic [15:0] i;
      logic [15:0] q;
   } raw_sample_t;

   // Place the two saturated components into their word fields; unused bits stay 0.
   function automatic logic [31:0] pack_word(input logic [IQ_W-1:0] i_val,
                                             input logic [IQ_W-1:0] q_val);
      logic [31:0] w;
      w = '0;
      w[I_LSB +: IQ_W] = i_val;
      w[Q_LSB +: IQ_W] = q_val;
      return w;
   endfunction

endpackage

// File: rtl/iq_saturate.sv
// Combinational 16-bit signed to 13-bit signed saturation with a clip indicator.
module iq_saturate
   import tx_path_pkg::*;
(
   input  logic [15:0]     i_val,
   output logic [IQ_W-1:0] o_val,
   output logic            o_clip
);

   localparam logic signed [15:0] MAX_V = 16'(SAT_MAX);
   localparam logic signed [15:0] MIN_V = 16'(SAT_MIN);

   // Clamp to the 13-bit range; in-range values just drop the redundant sign bits.
   always_comb begin
      o_val  = i_val[IQ_W-1:0];
      o_clip = 1'b0;
      if ($signed(i_val) > MAX_V) begin
         o_val  = MAX_V[IQ_W-1:0];
         o_clip = 1'b1;
      end else if ($signed(i_val) < MIN_V) begin
         o_val  = MIN_V[IQ_W-1:0];
         o_clip = 1'b1;
      end
   end

endmodule

// File: rtl/tx_sample_packer.sv
// Host byte stream -> saturated 32-bit I/Q words for the TX sample FIFO.
// Three stages: byte capture, saturation register, FIFO write stage.
module tx_sample_packer
   import tx_path_pkg::*;
#(
   parameter int DROP_CNT_W = 16
) (
   input  logic                  i_sys_clk,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic [7:0]            i_byte,
   input  logic                  i_byte_valid,
   input  logic                  i_frame_start,
   input  logic                  i_fifo_full,
   output logic                  o_fifo_wr,
   output logic [31:0]           o_fifo_data,
   output logic                  o_sync_err,
   output logic [DROP_CNT_W-1:0] o_drop_count,
   output logic                  o_sat_flag
);

   localparam logic [1:0] LAST_IDX = 2'(SAMPLE_BYTES - 1);

   state_e                state_q, state_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [2:0][7:0]       bytes_q, bytes_d;
   logic                  s1_vld_q, s1_vld_d;
   raw_sample_t           s1_q, s1_d;
   logic                  s2_vld_q, s2_vld_d;
   logic [31:0]           s2_word_q, s2_word_d;
   logic                  s3_vld_q, s3_vld_d;
   logic [31:0]           s3_word_q, s3_word_d;
   logic                  sync_err_q, sync_err_d;
   logic                  sat_q, sat_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   logic [IQ_W-1:0]       i_sat, q_sat;
   logic                  i_clip, q_clip;

   iq_saturate u_sat_i (.i_val(s1_q.i), .o_val(i_sat), .o_clip(i_clip));
   iq_saturate u_sat_q (.i_val(s1_q.q), .o_val(q_sat), .o_clip(q_clip));

   // Alignment FSM and byte capture; the Q_hi byte launches a complete sample into stage 1.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      bytes_d    = bytes_q;
      s1_vld_d   = 1'b0;
      s1_d       = s1_q;
      sync_err_d = 1'b0;
      if (!i_enable) begin
         // Partial bytes are silently abandoned; realignment needs a fresh frame start.
         state_d    = ALIGN;
         byte_idx_d = 2'd0;
      end else if (i_byte_valid) begin
         if (i_frame_start) begin
            sync_err_d = (state_q == ASSEMBLE) && (byte_idx_q != 2'd0);
            bytes_d[0] = i_byte;
            byte_idx_d = 2'd1;
            state_d    = ASSEMBLE;
         end else if (state_q == ASSEMBLE) begin
            if (byte_idx_q == LAST_IDX) begin
               s1_vld_d   = 1'b1;
               s1_d.i     = {bytes_q[1], bytes_q[0]};
               s1_d.q     = {i_byte, bytes_q[2]};
               byte_idx_d = 2'd0;
            end else begin
               case (byte_idx_q)
                  2'd0:    bytes_d[0] = i_byte;
                  2'd1:    bytes_d[1] = i_byte;
                  default: bytes_d[2] = i_byte;
               endcase
               byte_idx_d = byte_idx_q + 2'd1;
            end
         end
      end
   end

   // Saturation and write stages; these drain regardless of i_enable.
   always_comb begin
      s2_vld_d  = s1_vld_q;
      s2_word_d = s1_vld_q ? pack_word(i_sat, q_sat) : s2_word_q;
      s3_vld_d  = s2_vld_q;
      s3_word_d = s2_vld_q ? s2_word_q : s3_word_q;
      sat_d     = i_enable && (sat_q || (s1_vld_q && (i_clip || q_clip)));
      drop_d    = drop_q;
      if (s3_vld_q && i_fifo_full && !(&drop_q))
         drop_d = drop_q + DROP_CNT_W'(1);
   end

   // All state registers, synchronous reset.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         state_q    <= ALIGN;
         byte_idx_q <= 2'd0;
         bytes_q    <= '0;
         s1_vld_q   <= 1'b0;
         s1_q       <= '0;
         s2_vld_q   <= 1'b0;
         s2_word_q  <= '0;
         s3_vld_q   <= 1'b0;
         s3_word_q  <= '0;
         sync_err_q <= 1'b0;
         sat_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         bytes_q    <= bytes_d;
         s1_vld_q   <= s1_vld_d;
         s1_q       <= s1_d;
         s2_vld_q   <= s2_vld_d;
         s2_word_q  <= s2_word_d;
         s3_vld_q   <= s3_vld_d;
         s3_word_q  <= s3_word_d;
         sync_err_q <= sync_err_d;
         sat_q      <= sat_d;
         drop_q     <= drop_d;
      end
   end

   // The full flag is looked at in the write cycle itself, so the strobe is gated live.
   assign o_fifo_wr    = s3_vld_q && !i_fifo_full;
   assign o_fifo_data  = s3_word_q;
   assign o_sync_err   = sync_err_q;
   assign o_drop_count = drop_q;
   assign o_sat_flag   = sat_q;

endmodule

// File: tb/tb_tx_sample_packer.sv
module tb_tx_sample_packer;

   localparam int W    = 3;
   localparam int MAXD = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1, en = 1'b0, bv = 1'b0, fs = 1'b0, full = 1'b0;
   logic [7:0]    b = 8'h00;
   logic          o_fifo_wr, o_sync_err, o_sat_flag;
   logic [31:0]   o_fifo_data;
   logic [W-1:0]  o_drop_count;

   always #5 clk = ~clk;

   tx_sample_packer #(.DROP_CNT_W(W)) dut (
      .i_sys_clk(clk), .i_reset(rst), .i_enable(en), .i_byte(b),
      .i_byte_valid(bv), .i_frame_start(fs), .i_fifo_full(full),
      .o_fifo_wr(o_fifo_wr), .o_fifo_data(o_fifo_data), .o_sync_err(o_sync_err),
      .o_drop_count(o_drop_count), .o_sat_flag(o_sat_flag)
   );

   int tests = 0, fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int m_sat13(input int v);
      if (v > 4095) return 4095;
      if (v < -4096) return -4096;
      return v;
   endfunction

   function automatic logic [31:0] m_word(input int iv, input int qv);
      int si, sq;
      si = m_sat13(iv);
      sq = m_sat13(qv);
      return ((si & 32'h1FFF) << 16) | (sq & 32'h1FFF);
   endfunction

   function automatic bit m_clip(input int iv, input int qv);
      return (m_sat13(iv) != iv) || (m_sat13(qv) != qv);
   endfunction

   typedef struct {
      int          due;
      logic [31:0] word;
   } item_t;

   logic [7:0] partial[$];
   item_t      pend[$];
   bit         aligned = 0, m_sat = 0, m_clip_next = 0, m_err = 0;
   int         m_drop = 0, cyc = 0, mi, mq;

   // Model advances on each rising edge using the inputs held over the previous cycle.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         partial.delete(); pend.delete();
         aligned = 0; m_sat = 0; m_clip_next = 0; m_err = 0; m_drop = 0;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc - 1) begin
            if (full && m_drop < MAXD) m_drop++;
            void'(pend.pop_front());
         end
         m_sat = en ? (m_sat | m_clip_next) : 1'b0;
         m_clip_next = 0;
         m_err = 0;
         if (!en) begin
            partial.delete();
            aligned = 0;
         end else if (bv) begin
            if (fs) begin
               if (aligned && partial.size() != 0) m_err = 1;
               partial.delete();
               partial.push_back(b);
               aligned = 1;
            end else if (aligned) begin
               partial.push_back(b);
               if (partial.size() == 4) begin
                  mi = $signed({partial[1], partial[0]});
                  mq = $signed({partial[3], partial[2]});
                  pend.push_back('{cyc + 2, m_word(mi, mq)});
                  m_clip_next = m_clip(mi, mq);
                  partial.delete();
               end
            end
         end
      end
   end

   // Compare process: every cycle, away from the edge.
   bit          chk_on = 0;
   bit          exp_wr;
   int          wr_cnt = 0, err_cnt = 0;
   logic [31:0] last_data = '0;

   always @(negedge clk) begin
      if (chk_on) begin
         exp_wr = pend.size() > 0 && pend[0].due == cyc && !full;
         chk("fifo_wr", o_fifo_wr, exp_wr);
         if (exp_wr) chk("fifo_data", o_fifo_data, pend[0].word);
         chk("sync_err", o_sync_err, m_err);
         chk("drop_count", o_drop_count, m_drop);
         chk("sat_flag", o_sat_flag, m_sat);
      end
      if (o_fifo_wr) begin
         wr_cnt++;
         last_data = o_fifo_data;
      end
      if (o_sync_err) err_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit f, input logic [7:0] d);
      bv = v; fs = f; b = d;
      tick();
   endtask

   task automatic send_sample(input logic [15:0] iv, input logic [15:0] qv, input bit f);
      drive(1, f, iv[7:0]);
      drive(1, 0, iv[15:8]);
      drive(1, 0, qv[7:0]);
      drive(1, 0, qv[15:8]);
   endtask

   task automatic idle(input int n);
      bv = 0; fs = 0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1; bv = 0; fs = 0;
      tick(); tick();
      rst = 0;
   endtask

   int w0, e0;

   initial begin
      en = 1;
      do_reset();
      chk_on = 1;

      // model pinned against hand-computed words
      chk("model_nominal", m_word(32'sh0234, -564), 32'h02341DCC);
      chk("model_sat", m_word(32'sh7FFF, -32768), 32'h0FFF1000);
      chk("model_noclip_edge", m_clip(4095, -4096), 0);

      // reset state
      @(negedge clk);
      chk("rst_wr", o_fifo_wr, 0);
      chk("rst_data", o_fifo_data, 0);
      chk("rst_err", o_sync_err, 0);
      chk("rst_drop", o_drop_count, 0);
      chk("rst_sat", o_sat_flag, 0);
      tick();

      // nominal, with the write exactly two edges after the last byte's edge
      w0 = wr_cnt;
      send_sample(16'h0234, 16'hFDCC, 1);
      idle(1);
      @(negedge clk);
      chk("nominal_early", o_fifo_wr, 0);
      tick();
      @(negedge clk);
      chk("nominal_wr", o_fifo_wr, 1);
      chk("nominal_data", o_fifo_data, 32'h02341DCC);
      idle(2);
      chk("nominal_count", wr_cnt - w0, 1);

      // saturation, then in-range extremes
      send_sample(16'h7FFF, 16'h8000, 1);
      idle(2);
      @(negedge clk);
      chk("sat_data", o_fifo_data, 32'h0FFF1000);
      chk("sat_flag", o_sat_flag, 1);
      idle(2);
      send_sample(16'h0FFF, 16'hF000, 1);
      idle(2);
      @(negedge clk);
      chk("edge_data", o_fifo_data, 32'h0FFF1000);
      chk("edge_flag_sticky", o_sat_flag, 1);
      idle(2);
      en = 0; tick(); en = 1;
      @(negedge clk);
      chk("sat_clear_on_disable", o_sat_flag, 0);
      tick();

      // resync: partial sample abandoned by a new frame start
      send_sample(16'h0000, 16'h0000, 1);
      idle(4);
      w0 = wr_cnt; e0 = err_cnt;
      drive(1, 1, 8'hAA);
      drive(1, 0, 8'hBB);
      send_sample(16'h0123, 16'hFF00, 1);
      idle(4);
      chk("resync_err", err_cnt - e0, 1);
      chk("resync_wr", wr_cnt - w0, 1);
      chk("resync_data", last_data, 32'h01231F00);

      // frame start on byte 3 is an error and the old sample is lost
      w0 = wr_cnt; e0 = err_cnt;
      drive(1, 1, 8'h01); drive(1, 0, 8'h02); drive(1, 0, 8'h03);
      send_sample(16'h0042, 16'h0043, 1);
      idle(4);
      chk("idx3_err", err_cnt - e0, 1);
      chk("idx3_wr", wr_cnt - w0, 1);
      chk("idx3_data", last_data, 32'h00420043);

      // overflow and drop counter saturation
      do_reset();
      w0 = wr_cnt;
      full = 1;
      send_sample(16'h0001, 16'h0002, 1);
      repeat (4) send_sample(16'h0003, 16'h0004, 0);
      idle(4);
      chk("ovf_nowr", wr_cnt - w0, 0);
      chk("ovf_drop5", o_drop_count, 5);
      repeat (3) send_sample(16'h0005, 16'h0006, 0);
      idle(4);
      chk("ovf_drop_sat", o_drop_count, MAXD);
      full = 0;
      send_sample(16'h0007, 16'h0008, 0);
      idle(4);
      chk("ovf_release_wr", wr_cnt - w0, 1);
      chk("ovf_drop_hold", o_drop_count, MAXD);

      // reset one cycle after the last byte kills the in-flight word
      w0 = wr_cnt;
      send_sample(16'h7FFF, 16'h0001, 1);
      rst = 1;
      tick();
      @(negedge clk);
      chk("rstmid_wr", o_fifo_wr, 0);
      chk("rstmid_data", o_fifo_data, 0);
      chk("rstmid_err", o_sync_err, 0);
      chk("rstmid_drop", o_drop_count, 0);
      chk("rstmid_sat", o_sat_flag, 0);
      rst = 0;
      idle(6);
      chk("rstmid_nowr", wr_cnt - w0, 0);

      // alignment: nothing until a frame start; enable drop is silent
      w0 = wr_cnt; e0 = err_cnt;
      repeat (6) drive(1, 0, 8'h5A);
      idle(4);
      chk("align_nowr", wr_cnt - w0, 0);
      drive(1, 1, 8'h11);
      drive(1, 0, 8'h22);
      en = 0; tick(); en = 1;
      send_sample(16'hF000, 16'h0FFF, 1);
      idle(4);
      chk("enable_noerr", err_cnt - e0, 0);
      chk("enable_wr", wr_cnt - w0, 1);
      chk("enable_data", last_data, 32'h10000FFF);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         rst  = ($urandom_range(0, 499) == 0);
         en   = ($urandom_range(0, 39) != 0);
         bv   = ($urandom_range(0, 4) != 0);
         fs   = bv && ($urandom_range(0, 9) == 0);
         b    = 8'($urandom);
         full = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 0; en = 1; full = 0;
      idle(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
